dac_share_arbiter: RTL and testbench

Shares one binary-weighted DAC between NUM_REQ requesters. Each requester offers a code over a valid/ready handshake. Grants rotate round-robin, and each accepted code is presented to the DAC for a load cycle followed by a fixed settle window before the next grant. Sits between the channel controllers (bias and trim loops) and the DAC's digital input.

---
 rtl/dac_ctrl_pkg.sv | 20 ++
 rtl/dac_share_arbiter_rr_arbiter.sv | 33 +++
 rtl/dac_share_arbiter.sv | 86 ++++++++
 tb/tb_dac_share_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dac_ctrl_pkg.sv
// Shared types and width helpers for the DAC sharing arbiter.
package dac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE
  } dac_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Counter width able to hold values 0..s, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned s);
    return (s <= 1) ? 1 : $clog2(s + 1);
  endfunction

endpackage

// File: rtl/dac_share_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker: first requester at or after rr_ptr wins.
module rr_arbiter
  import dac_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_grant
);

  logic [IW-1:0] idx;

  // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ and take the first active request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = IW'((32'(rr_ptr) + off) % NUM_REQ);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_share_arbiter.sv
// Round-robin sharing of one DAC: grant, one-cycle load, fixed settle window.
module dac_share_arbiter
  import dac_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  localparam int unsigned IW           = idx_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_code,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         dac_code,
  output logic                     dac_load,
  output logic [IW-1:0]            active_id,
  output logic                     busy
);

  localparam int unsigned CW = cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = (SETTLE_CYCLES == 0) ? '0 : CW'(SETTLE_CYCLES - 1);

  dac_state_e           state, state_next;
  logic [IW-1:0]        rr_ptr;
  logic [CW-1:0]        cnt;
  logic [NUM_REQ-1:0]   grant;
  logic [IW-1:0]        grant_idx;
  logic                 any_grant;
  logic                 accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Handshake and status outputs; no grant is offered while reset is asserted.
  always_comb begin
    accept    = (state == IDLE) && any_grant && !rst;
    req_ready = accept ? grant : '0;
    dac_load  = (state == LOAD);
    busy      = (state != IDLE);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_grant) state_next = LOAD;
      LOAD:    state_next = (SETTLE_CYCLES == 0) ? IDLE : SETTLE;
      SETTLE:  if (cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Pointer, settle counter and DAC-facing output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      cnt       <= '0;
      dac_code  <= '0;
      active_id <= '0;
    end else begin
      if (accept) begin
        dac_code  <= req_code[32'(grant_idx)*WIDTH +: WIDTH];
        active_id <= grant_idx;
        rr_ptr    <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state == LOAD) cnt <= CNT_LOAD;
      else if (state == SETTLE && cnt != '0) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_dac_share_arbiter.sv
// Scoreboard bench: two builds (settle 4 and settle 0) share one requester set.
module tb_dac_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_code  = '0;

  logic [N-1:0] a_ready, b_ready;
  logic [W-1:0] a_code, b_code;
  logic         a_load, b_load, a_busy, b_busy;
  logic [1:0]   a_id, b_id;

  dac_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code),
    .req_ready(a_ready), .dac_code(a_code), .dac_load(a_load),
    .active_id(a_id), .busy(a_busy)
  );

  dac_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code),
    .req_ready(b_ready), .dac_code(b_code), .dac_load(b_load),
    .active_id(b_id), .busy(b_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int id;
    int code;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model state per build: next pointer, first cycle a grant is
  // allowed, last acceptance cycle, and the code/id the DAC should show.
  int m_ptr[2]  = '{0, 0};
  int m_free[2] = '{0, 0};
  int m_last[2] = '{0, 0};
  int m_code[2] = '{0, 0};
  int m_id[2]   = '{0, 0};

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  task automatic model_step(input int k, input int s, input int rdy,
                            input int code, input int id, input int bsy);
    string p;
    int    exp_rdy;
    int    g;
    int    i;
    exp_t  e;
    p       = (k == 0) ? "s4" : "s0";
    exp_rdy = 0;
    g       = -1;
    check({p, "_dac_code"}, code, m_code[k]);
    check({p, "_active_id"}, id, m_id[k]);
    check({p, "_busy"}, bsy, (cyc > m_last[k] && cyc < m_free[k]) ? 1 : 0);
    if (rst) begin
      m_ptr[k]  = 0;
      m_free[k] = cyc + 1;
      m_last[k] = cyc;
      m_code[k] = 0;
      m_id[k]   = 0;
    end else if (cyc >= m_free[k] && req_valid != '0) begin
      for (int o = 0; o < N; o++) begin
        i = (m_ptr[k] + o) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
      exp_rdy   = 1 << g;
      e.cyc     = cyc;
      e.id      = g;
      e.code    = int'((req_code >> (g * W)) & 32'hFF);
      if (k == 0) qa.push_back(e);
      else        qb.push_back(e);
      m_code[k] = e.code;
      m_id[k]   = g;
      m_ptr[k]  = (g + 1) % N;
      m_last[k] = cyc;
      m_free[k] = cyc + s + 2;
    end
    check({p, "_req_ready"}, rdy, exp_rdy);
  endtask

  task automatic mon(input int k, input logic load, input int code, input int id);
    string p;
    bit    have;
    exp_t  e;
    p    = (k == 0) ? "s4" : "s0";
    have = (k == 0) ? (qa.size() > 0) : (qb.size() > 0);
    if (have) e = (k == 0) ? qa[0] : qb[0];
    if (load) begin
      if (!have) begin
        check({p, "_unexpected_load"}, int'(load), 0);
      end else begin
        if (k == 0) void'(qa.pop_front());
        else        void'(qb.pop_front());
        check({p, "_load_latency"}, cyc, e.cyc + 1);
        check({p, "_load_code"}, code, e.code);
        check({p, "_load_id"}, id, e.id);
      end
    end else if (have && e.cyc + 1 <= cyc) begin
      if (k == 0) void'(qa.pop_front());
      else        void'(qb.pop_front());
      check({p, "_missing_load"}, int'(load), 1);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DAC load pulse is presented.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      mon(0, a_load, int'(a_code), int'(a_id));
      mon(1, b_load, int'(b_code), int'(b_id));
    end
  end

  task automatic tick(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] c);
    @(negedge clk);
    cyc++;
    rst       = r;
    req_valid = v;
    req_code  = c;
    #1;
    model_step(0, 4, int'(a_ready), int'(a_code), int'(a_id), int'(a_busy));
    model_step(1, 0, int'(b_ready), int'(b_code), int'(b_id), int'(b_busy));
  endtask

  logic [N-1:0]   cur_v;
  logic [N*W-1:0] cur_c;

  initial begin
    // Reset held with all requesters valid, then first grant to 0.
    for (int j = 0; j < 3; j++) tick(1'b1, 4'hF, 32'h40302010);
    tick(1'b0, 4'hF, 32'h40302010);
    for (int j = 0; j < 8; j++) tick(1'b0, 4'h0, 32'h0);

    // Single transfer from requester 2.
    tick(1'b0, 4'b0100, 32'h00A50000);
    for (int j = 0; j < 8; j++) tick(1'b0, 4'h0, 32'h0);

    // Round-robin with all requesters continuously valid.
    for (int j = 0; j < 30; j++) tick(1'b0, 4'hF, 32'h40302010);
    for (int j = 0; j < 8; j++) tick(1'b0, 4'h0, 32'h0);

    // Skip and wrap: bring pointer to 3, then only 0 and 1 request.
    tick(1'b0, 4'b0100, 32'h00330000);
    for (int j = 0; j < 8; j++) tick(1'b0, 4'h0, 32'h0);
    for (int j = 0; j < 12; j++) tick(1'b0, 4'b0011, 32'h0000BBAA);
    for (int j = 0; j < 8; j++) tick(1'b0, 4'h0, 32'h0);

    // Reset two cycles into the settle window after loading 0xFF.
    tick(1'b0, 4'b1000, 32'hFF000000);
    for (int j = 0; j < 3; j++) tick(1'b0, 4'h0, 32'h0);
    tick(1'b1, 4'h0, 32'h0);
    for (int j = 0; j < 3; j++) tick(1'b0, 4'h0, 32'h0);
    for (int j = 0; j < 6; j++) tick(1'b0, 4'b0010, 32'h00005A00);
    for (int j = 0; j < 8; j++) tick(1'b0, 4'h0, 32'h0);

    // Randomized requesters; codes only change while a requester is not valid.
    cur_v = '0;
    cur_c = '0;
    for (int j = 0; j < 400; j++) begin
      for (int i = 0; i < N; i++) begin
        if (cur_v[i]) begin
          if ($urandom_range(0, 7) == 0) cur_v[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          cur_v[i] = 1'b1;
          cur_c[i*W +: W] = W'($urandom);
        end
      end
      tick(1'b0, cur_v, cur_c);
    end
    for (int j = 0; j < 10; j++) tick(1'b0, 4'h0, 32'h0);

    check("s4_pending_loads", qa.size(), 0);
    check("s0_pending_loads", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
